// File: rtl/pio_read_scheduler.sv
// Read scheduler for the 32-bit input PIO slave: round-robin sharing of the
// slave's single read port among NUM_REQ requesters plus a periodic poll of
// address 0 with sticky change detection.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req, req_addr         per-requester read request (level) and 2-bit address
//   gnt, rsp_valid        one-hot grant pulse / one-hot response pulse
//   rsp_data              data of the most recent external response
//   busy                  high whenever the sequencer is not idle
//   pio_address           registered address to the PIO slave
//   pio_readdata          registered readdata from the PIO slave
//   last_sample           most recent poll result
//   change_irq, irq_clr   sticky poll-change interrupt and its clear
module pio_read_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int POLL_PERIOD = 1000,
    parameter int POLL_EN     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_addr,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   busy,
    output logic [1:0]             pio_address,
    input  logic [31:0]            pio_readdata,
    output logic [31:0]            last_sample,
    output logic                   change_irq,
    input  logic                   irq_clr
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(POLL_PERIOD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [IW-1:0]      win_q, win_d;
    logic               poll_q, poll_d;
    logic [1:0]         addr_q, addr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [31:0]        last_q, last_d;
    logic               irq_q, irq_d;

    logic               poll_sel;
    logic               ext_found;
    logic [IW-1:0]      ext_win;
    logic [1:0]         ext_addr;
    logic [IW-1:0]      ext_next;
    logic               expire;
    logic               pend_clr;
    logic               irq_set;

    assign poll_sel = (POLL_EN != 0) && pend_q;

    // First requesting index at or after the RR pointer, with wrap-around.
    always_comb begin
        int j;
        int n;
        j         = 0;
        n         = 0;
        ext_found = 1'b0;
        ext_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!ext_found && req[IW'(j)]) begin
                ext_found = 1'b1;
                ext_win   = IW'(j);
            end
        end
        ext_addr = 2'(req_addr >> (2 * int'(ext_win)));
        n        = int'(ext_win) + 1;
        if (n >= NUM_REQ) n = 0;
        ext_next = IW'(n);
    end

    // gnt is combinational so it lands in the IDLE cycle of the decision.
    always_comb begin
        gnt = '0;
        if (reset_n && state_q == S_IDLE && !poll_sel && ext_found)
            gnt = NUM_REQ'(1) << ext_win;
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        poll_d      = poll_q;
        addr_d      = addr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        last_d      = last_q;
        pend_clr    = 1'b0;
        irq_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (poll_sel) begin
                    state_d  = S_ISSUE;
                    poll_d   = 1'b1;
                    addr_d   = 2'd0;
                    pend_clr = 1'b1;
                end else if (ext_found) begin
                    state_d = S_ISSUE;
                    poll_d  = 1'b0;
                    addr_d  = ext_addr;
                    win_d   = ext_win;
                    rr_d    = ext_next;
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                state_d = S_IDLE;
                if (poll_q) begin
                    last_d  = pio_readdata;
                    irq_set = (pio_readdata != last_q);
                end else begin
                    rsp_data_d  = pio_readdata;
                    rsp_valid_d = NUM_REQ'(1) << win_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A fresh expiry wins over the clear of a poll granted the same cycle.
    always_comb begin
        expire = 1'b0;
        cnt_d  = '0;
        pend_d = 1'b0;
        if (POLL_EN != 0) begin
            if (cnt_q == CW'(POLL_PERIOD - 1)) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            pend_d = expire | (pend_q & ~pend_clr);
        end
    end

    assign irq_d = irq_set | (irq_q & ~irq_clr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            win_q       <= '0;
            poll_q      <= 1'b0;
            addr_q      <= 2'd0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            last_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            win_q       <= win_d;
            poll_q      <= poll_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            last_q      <= last_d;
            irq_q       <= irq_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != S_IDLE);
    assign pio_address = addr_q;
    assign last_sample = last_q;
    assign change_irq  = irq_q;

endmodule

// File: tb/tb_pio_read_scheduler.sv
// Scoreboard bench for pio_read_scheduler: a transaction-level reference
// model predicts grants and responses, a monitor checks responses.
module tb_pio_read_scheduler;

    localparam int N = 4;
    localparam int P = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_addr = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_data;
    logic           busy;
    logic [1:0]     pio_address;
    logic [31:0]    pio_readdata = '0;
    logic [31:0]    last_sample;
    logic           change_irq;
    logic           irq_clr = 1'b0;
    logic [31:0]    in_port = '0;

    pio_read_scheduler #(
        .NUM_REQ(N),
        .POLL_PERIOD(P),
        .POLL_EN(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_addr(req_addr),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .pio_address(pio_address),
        .pio_readdata(pio_readdata),
        .last_sample(last_sample),
        .change_irq(change_irq),
        .irq_clr(irq_clr)
    );

    // PIO slave: registered readdata, only address 0 is populated.
    always @(posedge clk)
        pio_readdata <= (pio_address == 2'd0) ? in_port : 32'd0;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc_cnt);
        end
    endtask

    // Reference model state: phase of the current read (0 none, 1 address
    // out, 2 data back), poll bookkeeping and the interrupt/sample state.
    int          m_phase = 0;
    int          m_rr = 0;
    int          m_cnt = 0;
    bit          m_pend = 0;
    bit          m_poll = 0;
    bit          m_irq = 0;
    int          m_win = 0;
    logic [1:0]  m_addr = 2'd0;
    logic [31:0] m_data = '0;
    logic [31:0] m_last = '0;

    task automatic model_step();
        logic [N-1:0] exp_gnt;
        bit found;
        bit set;
        int j;
        rsp_t e;
        exp_gnt = '0;
        found = 0;
        set = 0;
        if (!reset_n) begin
            chk("gnt_in_reset", gnt, '0);
            m_phase = 0; m_rr = 0; m_cnt = 0; m_pend = 0;
            m_poll = 0; m_irq = 0; m_last = '0;
            q.delete();
            return;
        end
        chk("busy", busy, (m_phase != 0));
        chk("last_sample", last_sample, m_last);
        chk("change_irq", change_irq, m_irq);
        if (m_phase == 0) begin
            if (m_pend) begin
                m_poll = 1; m_addr = 2'd0; m_pend = 0; m_phase = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (!found && req[j]) begin
                        found = 1;
                        m_win = j;
                    end
                end
                if (found) begin
                    exp_gnt = N'(1) << m_win;
                    m_addr = 2'(req_addr >> (2 * m_win));
                    m_rr = (m_win + 1) % N;
                    m_poll = 0;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            chk("pio_address", pio_address, m_addr);
            m_data = (m_addr == 2'd0) ? in_port : 32'd0;
            m_phase = 2;
        end else begin
            if (m_poll) begin
                set = (m_data != m_last);
                m_last = m_data;
            end else begin
                e.idx = m_win;
                e.data = m_data;
                e.due = cyc_cnt + 1;
                q.push_back(e);
            end
            m_phase = 0;
        end
        m_irq = set ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
        chk("gnt", gnt, exp_gnt);
        if (m_cnt == P - 1) begin
            m_cnt = 0;
            m_pend = 1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [2*N-1:0] ra,
                       input logic [31:0] ip, input logic clr,
                       input logic rst);
        @(negedge clk);
        req = r;
        req_addr = ra;
        in_port = ip;
        irq_clr = clr;
        reset_n = rst;
        #1;
        model_step();
    endtask

    // Monitor: every response pulse must match the oldest expected one.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (rsp_valid !== '0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got %b expected none at cycle %0d",
                         rsp_valid, cyc_cnt);
            end else begin
                e = q.pop_front();
                chk("rsp_valid", rsp_valid, N'(1) << e.idx);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_cycle", cyc_cnt, e.due);
            end
        end
    end

    initial begin
        logic [31:0] ip;
        int guard;
        ip = 32'd0;

        repeat (2) cyc('0, '0, '0, 1'b0, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_pio_address", pio_address, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_busy", busy, '0);
        chk("rst_last_sample", last_sample, '0);
        chk("rst_change_irq", change_irq, '0);

        // single read from requester 0
        cyc(4'b0001, '0, 32'hA5A5_0001, 1'b0, 1'b1);
        repeat (6) cyc('0, '0, 32'hA5A5_0001, 1'b0, 1'b1);

        // all requesters held: round-robin
        repeat (16) cyc(4'b1111, '0, 32'h1234_0000, 1'b0, 1'b1);
        repeat (4) cyc('0, '0, 32'h1234_0000, 1'b0, 1'b1);

        // requester 1 reads address 2
        repeat (3) cyc(4'b0010, 8'b0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        repeat (4) cyc('0, '0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // polls against a held requester, value 0 then FF, then clear
        repeat (20) cyc(4'b0100, '0, 32'h0, 1'b0, 1'b1);
        repeat (20) cyc(4'b0100, '0, 32'hFF, 1'b0, 1'b1);
        cyc(4'b0100, '0, 32'hFF, 1'b1, 1'b1);
        repeat (20) cyc(4'b0100, '0, 32'hFF, 1'b0, 1'b1);

        // clear held high while the sampled value keeps changing
        for (int i = 0; i < 30; i++)
            cyc('0, '0, 32'(i * 7 + 1), 1'b1, 1'b1);
        repeat (4) cyc('0, '0, 32'h0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) ip = 32'($urandom_range(3));
            cyc(N'($urandom), 8'($urandom), ip,
                ($urandom_range(9) == 0),
                !($urandom_range(199) == 0));
        end
        repeat (6) cyc('0, '0, ip, 1'b0, 1'b1);

        // reset while the read address is out
        guard = 0;
        do begin
            cyc(4'b1111, '0, 32'h55, 1'b0, 1'b1);
            guard++;
        end while (m_phase != 1 && guard < 10);
        chk("reach_issue", m_phase, 1);
        cyc(4'b1111, '0, 32'h55, 1'b0, 1'b0);
        cyc(4'b1010, '0, 32'h55, 1'b0, 1'b1);
        chk("first_gnt_after_reset", gnt, 4'b0010);
        repeat (12) cyc('0, '0, 32'h55, 1'b0, 1'b1);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
